// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared opcodes, funct3 codes, FSM states and access-size helpers
//
// Purpose: constants and small helpers imported by mem_access and mem_access_ld_ext.
// Ports:   none (package).
package mem_access_pkg;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_XFER = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  // Bytes moved by an access. The unsigned variants only exist for loads,
  // so on a store they (like any other unknown code) fall back to a word.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3, input logic is_load);
    case (funct3)
      FUNCT3_LB:  return 3'd1;
      FUNCT3_LH:  return 3'd2;
      FUNCT3_LBU: return is_load ? 3'd1 : 3'd4;
      FUNCT3_LHU: return is_load ? 3'd2 : 3'd4;
      default:    return 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] nbytes, input logic [1:0] addr_lo);
    return ((nbytes == 3'd2) && addr_lo[0]) || ((nbytes == 3'd4) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_ld_ext.sv
// rtl/mem_access_ld_ext.sv - load result sign/zero extension
//
// Purpose: turns the little-endian assembled load bytes into the rd value.
// Ports:
//   funct3  in  3   load width/sign select (B, H, W, BU, HU; unknown = W)
//   data    in  32  assembled bytes, byte k in data[8k+7:8k], unused bytes zero
//   result  out 32  extended rd value
module mem_access_ld_ext
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] data,
  output logic [31:0] result
);

  always_comb begin
    result = data;
    case (funct3)
      FUNCT3_LB:  result = {{24{data[7]}}, data[7:0]};
      FUNCT3_LH:  result = {{16{data[15]}}, data[15:0]};
      FUNCT3_LBU: result = {24'h000000, data[7:0]};
      FUNCT3_LHU: result = {16'h0000, data[15:0]};
      default:    result = data;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage load/store engine over a byte-wide data RAM
//
// Purpose: passes non-memory instructions straight through to mem_wb; splits
// stores into byte writes and assembles loads byte by byte, stalling the front
// of the pipeline while an access is in flight.
// Optional feature: define MEM_ACCESS_MISALIGN_CHK_EN to trap misaligned H/W
// accesses (no RAM cycle, misalign_o pulses in DONE).
// Ports:
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   valid_i, opcode_i, funct3_i instruction from ex_mem
//   we_i, waddr_i               rd write enable / index
//   alu_i, sdata_i              effective address or rd data / store data
//   adv_i                       ex_mem -> mem_wb advance from the stall controller
//   mem_din_i                   RAM read data, RD_LAT cycles after mem_a_o
//   mem_a_o, mem_dout_o, mem_wr_o   RAM address / write data / write strobe
//   mem_opcode_o, mem_we_o, mem_waddr_o, mem_wdata_o   write-back stream
//   stallreq_o                  hold IF..EX and ex_mem
//   misalign_o                  (feature only) misaligned access flag in DONE
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [31:0]       alu_i,
  input  logic [31:0]       sdata_i,
  input  logic              adv_i,
  input  logic [7:0]        mem_din_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  output logic [6:0]        mem_opcode_o,
  output logic              mem_we_o,
  output logic [4:0]        mem_waddr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              stallreq_o
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
  ,
  output logic              misalign_o
`endif
);

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  mem_state_e        state_q, state_d;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sdata_q;
  logic [31:0]       asm_q;
  logic [2:0]        funct3_q;
  logic [2:0]        nbytes_q;
  logic [6:0]        opcode_q;
  logic              we_q;
  logic [4:0]        waddr_q;
  logic              load_q;
  logic              mis_q;

  logic              is_load, is_store, is_ldst;
  logic [2:0]        nbytes_in;
  logic              mis_in;
  logic [2:0]        last_cnt;
  logic [1:0]        cap_idx;
  logic [31:0]       ld_result;

  assign is_load   = (opcode_i == OPCODE_LOAD);
  assign is_store  = (opcode_i == OPCODE_STORE);
  assign is_ldst   = valid_i && (is_load || is_store);
  assign nbytes_in = access_bytes(funct3_i, is_load);

`ifdef MEM_ACCESS_MISALIGN_CHK_EN
  assign mis_in     = is_misaligned(nbytes_in, alu_i[1:0]);
  assign misalign_o = (state_q == MEM_DONE) && mis_q && !rst;
`else
  assign mis_in     = 1'b0;
`endif

  // Stores finish with the last write; loads must also wait out the read
  // latency of the final byte, so their counter runs RD_LAT cycles further.
  assign last_cnt = load_q ? (nbytes_q + RD_LAT_C - 3'd1) : (nbytes_q - 3'd1);
  // Byte landing on mem_din_i this cycle was issued RD_LAT cycles ago.
  assign cap_idx  = 2'(cnt_q - RD_LAT_C);

  mem_access_ld_ext u_ld_ext (
    .funct3 (funct3_q),
    .data   (asm_q),
    .result (ld_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_a_o      = '0;
    mem_dout_o   = 8'h00;
    mem_wr_o     = 1'b0;
    mem_opcode_o = 7'h00;
    mem_we_o     = 1'b0;
    mem_waddr_o  = 5'd0;
    mem_wdata_o  = 32'h0;
    stallreq_o   = 1'b0;

    case (state_q)
      MEM_IDLE: begin
        if (is_ldst) begin
          state_d      = mis_in ? MEM_DONE : MEM_XFER;
          stallreq_o   = 1'b1;
          mem_opcode_o = opcode_i;
          mem_waddr_o  = waddr_i;
        end else begin
          mem_opcode_o = opcode_i;
          mem_we_o     = we_i;
          mem_waddr_o  = waddr_i;
          mem_wdata_o  = alu_i;
        end
      end

      MEM_XFER: begin
        stallreq_o   = 1'b1;
        mem_opcode_o = opcode_q;
        mem_waddr_o  = waddr_q;
        if (!load_q) begin
          mem_wr_o   = 1'b1;
          mem_a_o    = addr_q + ADDR_W'(cnt_q);
          mem_dout_o = sdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end else if (cnt_q < nbytes_q) begin
          mem_a_o    = addr_q + ADDR_W'(cnt_q);
        end
        if (cnt_q == last_cnt) begin
          state_d = MEM_DONE;
        end
      end

      MEM_DONE: begin
        mem_opcode_o = opcode_q;
        mem_waddr_o  = waddr_q;
        mem_we_o     = we_q && load_q && (waddr_q != 5'd0) && !mis_q;
        mem_wdata_o  = (load_q && !mis_q) ? ld_result : 32'h0;
        // valid_i is deliberately not looked at here: the same instruction
        // may still be sitting in ex_mem and must not be executed twice.
        if (adv_i) begin
          state_d = MEM_IDLE;
        end
      end

      default: state_d = MEM_IDLE;
    endcase

    // Reset silences every output at once so no write strobe or partial
    // result escapes during an aborted access.
    if (rst) begin
      state_d      = MEM_IDLE;
      mem_a_o      = '0;
      mem_dout_o   = 8'h00;
      mem_wr_o     = 1'b0;
      mem_opcode_o = 7'h00;
      mem_we_o     = 1'b0;
      mem_waddr_o  = 5'd0;
      mem_wdata_o  = 32'h0;
      stallreq_o   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      sdata_q  <= 32'h0;
      asm_q    <= 32'h0;
      funct3_q <= 3'd0;
      nbytes_q <= 3'd0;
      opcode_q <= 7'h00;
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      load_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (is_ldst) begin
            cnt_q    <= 3'd0;
            addr_q   <= alu_i[ADDR_W-1:0];
            sdata_q  <= sdata_i;
            asm_q    <= 32'h0;
            funct3_q <= funct3_i;
            nbytes_q <= nbytes_in;
            opcode_q <= opcode_i;
            we_q     <= we_i;
            waddr_q  <= waddr_i;
            load_q   <= is_load;
            mis_q    <= mis_in;
          end
        end
        MEM_XFER: begin
          cnt_q <= cnt_q + 3'd1;
          if (load_q && (cnt_q >= RD_LAT_C)) begin
            asm_q[{cap_idx, 3'b000} +: 8] <= mem_din_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard bench for mem_access with a byte-RAM model
module tb_mem_access;

  localparam int ADDR_W = 32;
  localparam int RD_LAT = 1;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_ALU   = 7'h33;
  localparam logic [6:0] OP_ALUI  = 7'h13;
  localparam logic [6:0] OP_LUI   = 7'h37;
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic        we_i = 1'b0;
  logic [4:0]  waddr_i = '0;
  logic [31:0] alu_i = '0;
  logic [31:0] sdata_i = '0;
  logic        adv_i = 1'b0;
  logic [7:0]  mem_din_i;
  logic [ADDR_W-1:0] mem_a_o;
  logic [7:0]  mem_dout_o;
  logic        mem_wr_o;
  logic [6:0]  mem_opcode_o;
  logic        mem_we_o;
  logic [4:0]  mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic        stallreq_o;
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .opcode_i     (opcode_i),
    .funct3_i     (funct3_i),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .alu_i        (alu_i),
    .sdata_i      (sdata_i),
    .adv_i        (adv_i),
    .mem_din_i    (mem_din_i),
    .mem_a_o      (mem_a_o),
    .mem_dout_o   (mem_dout_o),
    .mem_wr_o     (mem_wr_o),
    .mem_opcode_o (mem_opcode_o),
    .mem_we_o     (mem_we_o),
    .mem_waddr_o  (mem_waddr_o),
    .mem_wdata_o  (mem_wdata_o),
    .stallreq_o   (stallreq_o)
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
    ,
    .misalign_o   (misalign_o)
`endif
  );

  // Environment RAM: byte-wide, read data appears RD_LAT cycles after the address.
  logic [7:0] ram [int unsigned];
  logic [7:0] rd_pipe [RD_LAT];

  function automatic logic [7:0] ram_rd(input int unsigned a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    rd_pipe[0] <= ram_rd(mem_a_o);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_wr_o) ram[mem_a_o] = mem_dout_o;
  end
  assign mem_din_i = rd_pipe[RD_LAT-1];

  // Reference model: architectural memory contents and expected responses.
  logic [7:0] mdl [int unsigned];

  function automatic logic [7:0] mdl_rd(input int unsigned a);
    return mdl.exists(a) ? mdl[a] : 8'h00;
  endfunction

  typedef struct {
    logic [6:0]  opcode;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          stall;
    int          writes;
    logic        mis;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;
  int stall_cnt = 0;
  int wr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: samples mid low phase, after the driver has settled its inputs.
  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    #3;
    if (rst || !mon_en) begin
      stall_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (stallreq_o) stall_cnt++;
      if (mem_wr_o) begin
        wr_cnt++;
        if (wr_q.size() == 0) begin
          check("unexpected_write_addr", mem_a_o, 32'hxxxxxxxx);
        end else begin
          w = wr_q.pop_front();
          check("write_addr", mem_a_o, w.a);
          check("write_data", {24'h0, mem_dout_o}, {24'h0, w.d});
        end
      end
      if (valid_i && !stallreq_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {25'h0, mem_opcode_o}, 32'hxxxxxxxx);
        end else if (adv_i) begin
          e = exp_q.pop_front();
          check("opcode", {25'h0, mem_opcode_o}, {25'h0, e.opcode});
          check("we", {31'h0, mem_we_o}, {31'h0, e.we});
          if (e.we) begin
            check("waddr", {27'h0, mem_waddr_o}, {27'h0, e.waddr});
            check("wdata", mem_wdata_o, e.wdata);
          end
          check("stall_cycles", stall_cnt, e.stall);
          check("ram_writes", wr_cnt, e.writes);
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
          check("misalign", {31'h0, misalign_o}, {31'h0, e.mis});
`endif
          stall_cnt = 0;
          wr_cnt = 0;
        end else begin
          e = exp_q[0];
          check("hold_we", {31'h0, mem_we_o}, {31'h0, e.we});
          if (e.we) check("hold_wdata", mem_wdata_o, e.wdata);
        end
      end
    end
  end

  // Builds the expected response from the architectural rules, then drives
  // the instruction, holding adv_i low for `hold` extra cycles once the
  // stage stops stalling.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic we,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd,
                       input int hold, input bit use_force, input logic [31:0] force_val);
    exp_t e;
    int n;
    int hold_left;
    int guard;
    bit done;
    logic [31:0] v;
    e.opcode = op; e.waddr = rd; e.mis = 1'b0; e.stall = 0; e.writes = 0;
    if (op == OP_LOAD || op == OP_STORE) begin
      if (f3 == 3'b000 || (op == OP_LOAD && f3 == 3'b100)) n = 1;
      else if (f3 == 3'b001 || (op == OP_LOAD && f3 == 3'b101)) n = 2;
      else n = 4;
      e.mis = MIS_EN && ((n == 2 && alu[0]) || (n == 4 && alu[1:0] != 2'b00));
      e.we = 1'b0;
      e.wdata = 32'h0;
      if (e.mis) begin
        e.stall = 1;
      end else if (op == OP_STORE) begin
        for (int k = 0; k < n; k++) begin
          wr_t w;
          w.a = alu + k;
          w.d = 8'((sd >> (8 * k)) & 32'hFF);
          mdl[w.a] = w.d;
          wr_q.push_back(w);
        end
        e.stall = 1 + n;
        e.writes = n;
      end else begin
        v = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(mdl_rd(alu + k)) << (8 * k));
        case (f3)
          3'b000: v = (v >= 32'h80)   ? v + 32'hFFFFFF00 : v;
          3'b001: v = (v >= 32'h8000) ? v + 32'hFFFF0000 : v;
          default: ;
        endcase
        e.wdata = use_force ? force_val : v;
        e.we = we && (rd != 5'd0);
        e.stall = 1 + n + RD_LAT;
      end
    end else begin
      e.we = we;
      e.wdata = alu;
    end
    exp_q.push_back(e);

    @(negedge clk);
    valid_i = 1'b1; opcode_i = op; funct3_i = f3; we_i = we; waddr_i = rd;
    alu_i = alu; sdata_i = sd; adv_i = 1'b0;
    hold_left = hold; guard = 0; done = 1'b0;
    while (!done) begin
      #1;
      if (!stallreq_o && hold_left == 0) begin
        adv_i = 1'b1;
      end else begin
        adv_i = 1'b0;
        if (!stallreq_o) hold_left--;
      end
      @(posedge clk);
      if (adv_i) begin
        done = 1'b1;
      end else begin
        guard++;
        if (guard > 60) begin
          n_checks++;
          n_errors++;
          $display("FAIL timeout: instruction op=0x%02h never completed, required completion within 60 cycles", op);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic bubble(input logic [6:0] op);
    @(negedge clk);
    valid_i = 1'b0; opcode_i = op; funct3_i = 3'b010; we_i = 1'b1;
    alu_i = 32'h0000_0300; sdata_i = 32'hDEAD_BEEF; adv_i = 1'b1;
    @(posedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + $urandom_range(0, 15);
    return 32'h0000_0300 + $urandom_range(0, 63);
  endfunction

  initial begin
    logic [6:0] op;
    logic [7:0] b;
    // Shared initial contents of RAM and model.
    for (int unsigned a = 32'h300; a < 32'h340; a++) begin
      b = 8'($urandom);
      ram[a] = b; mdl[a] = b;
    end
    for (int unsigned a = 32'hFFFF_FFF0; a != 32'h0; a++) begin
      b = 8'($urandom);
      ram[a] = b; mdl[a] = b;
    end
    ram[32'h200] = 8'h80; ram[32'h201] = 8'hFF; ram[32'h202] = 8'h01; ram[32'h203] = 8'h02;
    mdl[32'h200] = 8'h80; mdl[32'h201] = 8'hFF; mdl[32'h202] = 8'h01; mdl[32'h203] = 8'h02;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk); #3;
    check("reset_mem_wr", {31'h0, mem_wr_o}, 32'h0);
    check("reset_stallreq", {31'h0, stallreq_o}, 32'h0);
    check("reset_mem_we", {31'h0, mem_we_o}, 32'h0);
    check("reset_wdata", mem_wdata_o, 32'h0);
    check("reset_mem_a", mem_a_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // ALU pass-through, store word, loads of every width, hold in DONE.
    issue(OP_ALU, 3'b000, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 0, 1'b1, 32'h0);
    issue(OP_STORE, 3'b010, 1'b0, 5'd0, 32'h0000_0100, 32'hA1B2_C3D4, 0, 1'b0, 32'h0);
    issue(OP_LOAD, 3'b000, 1'b1, 5'd3, 32'h0000_0200, 32'h0, 0, 1'b1, 32'hFFFF_FF80);
    issue(OP_LOAD, 3'b100, 1'b1, 5'd3, 32'h0000_0200, 32'h0, 0, 1'b1, 32'h0000_0080);
    issue(OP_LOAD, 3'b001, 1'b1, 5'd3, 32'h0000_0200, 32'h0, 0, 1'b1, 32'hFFFF_FF80);
    issue(OP_LOAD, 3'b101, 1'b1, 5'd3, 32'h0000_0200, 32'h0, 0, 1'b1, 32'h0000_FF80);
    issue(OP_LOAD, 3'b010, 1'b1, 5'd3, 32'h0000_0200, 32'h0, 3, 1'b1, 32'h0201_FF80);
    issue(OP_LOAD, 3'b111, 1'b1, 5'd7, 32'h0000_0200, 32'h0, 0, 1'b1, 32'h0201_FF80);
    issue(OP_LOAD, 3'b010, 1'b1, 5'd0, 32'h0000_0200, 32'h0, 0, 1'b0, 32'h0);
    issue(OP_LOAD, 3'b010, 1'b1, 5'd9, 32'h0000_0102, 32'h0, 0, 1'b0, 32'h0);
    issue(OP_STORE, 3'b010, 1'b0, 5'd0, 32'hFFFF_FFFE, 32'h5566_7788, 0, 1'b0, 32'h0);
    issue(OP_LOAD, 3'b010, 1'b1, 5'd4, 32'hFFFF_FFFE, 32'h0, 1, 1'b0, 32'h0);
    bubble(OP_STORE);
    bubble(OP_LOAD);
    check("sw_byte0", {24'h0, ram_rd(32'h100)}, 32'hD4);
    check("sw_byte1", {24'h0, ram_rd(32'h101)}, 32'hC3);
    check("sw_byte2", {24'h0, ram_rd(32'h102)}, 32'hB2);
    check("sw_byte3", {24'h0, ram_rd(32'h103)}, 32'hA1);
    check("wrap_byte0", {24'h0, ram_rd(32'h0)}, 32'h66);

    // Reset on the second byte of a store word.
    mon_en = 1'b0;
    @(negedge clk);
    valid_i = 1'b1; opcode_i = OP_STORE; funct3_i = 3'b010; we_i = 1'b0; waddr_i = 5'd0;
    alu_i = 32'h0000_0800; sdata_i = 32'h1122_3344; adv_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0; opcode_i = 7'h00; alu_i = 32'h0; sdata_i = 32'h0;
    @(posedge clk);
    @(negedge clk); #3;
    check("rst_abort_wr", {31'h0, mem_wr_o}, 32'h0);
    check("rst_abort_stall", {31'h0, stallreq_o}, 32'h0);
    check("rst_abort_we", {31'h0, mem_we_o}, 32'h0);
    check("rst_abort_wdata", mem_wdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #3;
    check("post_rst_wr", {31'h0, mem_wr_o}, 32'h0);
    check("post_rst_stall", {31'h0, stallreq_o}, 32'h0);
    check("rst_kept_byte0", {24'h0, ram_rd(32'h800)}, 32'h44);
    check("rst_no_byte2", {24'h0, ram_rd(32'h802)}, 32'h00);
    check("rst_no_byte3", {24'h0, ram_rd(32'h803)}, 32'h00);
    mon_en = 1'b1;

    // Randomised mix.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = OP_LOAD;
        3, 4, 5: op = OP_STORE;
        6:       op = OP_ALUI;
        7:       op = OP_LUI;
        default: op = OP_ALU;
      endcase
      if ($urandom_range(0, 7) == 0) bubble(op);
      issue(op, 3'($urandom_range(0, 7)), 1'($urandom), 5'($urandom),
            (op == OP_LOAD || op == OP_STORE) ? rand_addr() : $urandom,
            $urandom, $urandom_range(0, 2), 1'b0, 32'h0);
    end

    bubble(OP_ALU);
    bubble(OP_ALU);
    check("exp_queue_drained", exp_q.size(), 0);
    check("wr_queue_drained", wr_q.size(), 0);
    foreach (mdl[a]) check("final_ram", {24'h0, ram_rd(a)}, {24'h0, mdl[a]});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
